ls_exec_unit: RTL and testbench

//   Load/store execution stage that sits directly downstream of the load/store issue queue.
//   - Accepts the oldest ready memory operation from the queue (issuels_* handshake).
//   - Performs word accesses on the synchronous data memory.
//   - Broadcasts load results on the common data bus (CDB) through a request/grant arbiter.
//   - Stores complete locally and never use the CDB.

---
 rtl/ls_exec_unit_if.sv | 49 ++++
 rtl/ls_exec_unit.sv | 139 +++++++++++++
 tb/tb_ls_exec_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_exec_unit_if.sv
// Bus bundle for the load/store execution stage.
// It carries the issue-queue handshake, the data-memory port and the CDB
// request/grant port. The master modport is the execution unit's view.
// The slave modport is the view of the surrounding queue, memory and arbiter.
interface ls_exec_unit_if #(
   parameter int DMEM_AW = 10
);
   // issue queue -> execution unit
   logic                issuels_opcode;   // 1 = load, 0 = store
   logic [5:0]          issuels_rdtag;
   logic [31:0]         issuels_addr;
   logic [31:0]         issuels_data;
   logic                issuels_ready;
   logic                issuels_done;

   // synchronous data memory
   logic [DMEM_AW-1:0]  dmem_addr;
   logic [31:0]         dmem_wdata;
   logic                dmem_we;
   logic                dmem_re;
   logic [31:0]         dmem_rdata;

   // common data bus
   logic                lscdb_req;
   logic                lscdb_grant;
   logic [5:0]          lscdb_tag;
   logic [31:0]         lscdb_data;
   logic                lscdb_valid;

   modport master (
      input  issuels_opcode, issuels_rdtag, issuels_addr, issuels_data, issuels_ready,
      output issuels_done,
      output dmem_addr, dmem_wdata, dmem_we, dmem_re,
      input  dmem_rdata,
      output lscdb_req,
      input  lscdb_grant,
      output lscdb_tag, lscdb_data, lscdb_valid
   );

   modport slave (
      output issuels_opcode, issuels_rdtag, issuels_addr, issuels_data, issuels_ready,
      input  issuels_done,
      input  dmem_addr, dmem_wdata, dmem_we, dmem_re,
      output dmem_rdata,
      input  lscdb_req,
      output lscdb_grant,
      input  lscdb_tag, lscdb_data, lscdb_valid
   );
endinterface

// File: rtl/ls_exec_unit.sv
// Load/store execution stage behind the load/store issue queue.
// Stores are written to data memory in the cycle they are accepted.
// Loads wait MEM_LAT cycles for read data and then hold a CDB request until granted.
// Only one load is in flight at a time. While it is outstanding, nothing further is accepted.
// This preserves the memory order of the queue.
module ls_exec_unit #(
   parameter int DMEM_AW = 10,
   parameter int MEM_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,     // asynchronous, active low
   ls_exec_unit_if.master   bus,
   output logic             busy
);

   // The counter must hold MEM_LAT itself. It is at least one bit wide.
   localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_CDB  = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg,   cnt_next;
   logic [5:0]          tag_reg,   tag_next;
   logic [31:0]         data_reg,  data_next;

   // Combinational output values before reset gating.
   logic                done_c;
   logic [DMEM_AW-1:0]  addr_c;
   logic [31:0]         wdata_c;
   logic                we_c;
   logic                re_c;
   logic                req_c;
   logic [5:0]          cdb_tag_c;
   logic [31:0]         cdb_data_c;
   logic                valid_c;

   // Word address of the operation.
   // The byte-offset bits and the bits above the memory are discarded, so addresses wrap.
   logic [DMEM_AW-1:0]  word_addr;
   assign word_addr = bus.issuels_addr[DMEM_AW+1:2];

   // The dropped address bits are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.issuels_addr[31:DMEM_AW+2], bus.issuels_addr[1:0]};

   // Register the state, the latency counter and the captured load tag and data.
   // Reset drops any in-flight load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         tag_reg   <= '0;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         tag_reg   <= tag_next;
         data_reg  <= data_next;
      end
   end

   // Compute the next state and the raw outputs.
   // Acceptance in IDLE is combinational, so a store retires in the same cycle.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      tag_next   = tag_reg;
      data_next  = data_reg;
      done_c     = 1'b0;
      addr_c     = '0;
      wdata_c    = '0;
      we_c       = 1'b0;
      re_c       = 1'b0;
      req_c      = 1'b0;
      cdb_tag_c  = '0;
      cdb_data_c = '0;
      valid_c    = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (bus.issuels_ready) begin
               done_c = 1'b1;
               addr_c = word_addr;
               if (bus.issuels_opcode) begin
                  re_c       = 1'b1;
                  tag_next   = bus.issuels_rdtag;
                  cnt_next   = CNT_W'(MEM_LAT);
                  state_next = ST_MEM;
               end else begin
                  we_c    = 1'b1;
                  wdata_c = bus.issuels_data;
               end
            end
         end

         ST_MEM: begin
            // Read data is valid in the final latency cycle.
            // It is captured at the closing edge of that cycle.
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               data_next  = bus.dmem_rdata;
               state_next = ST_CDB;
            end
         end

         ST_CDB: begin
            // Hold the request, tag and data until the arbiter grants the bus.
            req_c      = 1'b1;
            cdb_tag_c  = tag_reg;
            cdb_data_c = data_reg;
            valid_c    = bus.lscdb_grant;
            if (bus.lscdb_grant) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Force every output low while reset is asserted, even the combinational responses.
   assign bus.issuels_done = reset & done_c;
   assign bus.dmem_addr    = reset ? addr_c : '0;
   assign bus.dmem_wdata   = reset ? wdata_c : '0;
   assign bus.dmem_we      = reset & we_c;
   assign bus.dmem_re      = reset & re_c;
   assign bus.lscdb_req    = reset & req_c;
   assign bus.lscdb_tag    = reset ? cdb_tag_c : '0;
   assign bus.lscdb_data   = reset ? cdb_data_c : '0;
   assign bus.lscdb_valid  = reset & valid_c;
   assign busy             = reset & (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ls_exec_unit.sv
// Directed bench for ls_exec_unit.
// dut1 uses a one-cycle memory backed by a small memory model.
// dut3 uses a three-cycle latency, and the bench drives a per-cycle marker
// on its read data to show which cycle is sampled.
module tb_ls_exec_unit;

   logic clk;
   logic reset;
   logic busy1;
   logic busy3;
   int   checks;
   int   errors;

   ls_exec_unit_if #(.DMEM_AW(10)) bus1();
   ls_exec_unit_if #(.DMEM_AW(10)) bus3();

   ls_exec_unit #(.DMEM_AW(10), .MEM_LAT(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1),
      .busy  (busy1)
   );

   ls_exec_unit #(.DMEM_AW(10), .MEM_LAT(3)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3),
      .busy  (busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory for dut1, with a one-cycle registered read.
   logic [31:0] mem [0:1023];
   logic [31:0] rdata_q;
   always @(posedge clk) begin
      if (bus1.dmem_we) mem[bus1.dmem_addr] <= bus1.dmem_wdata;
      if (bus1.dmem_re) rdata_q <= mem[bus1.dmem_addr];
   end
   assign bus1.dmem_rdata = rdata_q;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rdata_q = '0;
      reset = 1'b0;
      bus1.issuels_opcode = 1'b0; bus1.issuels_rdtag = '0; bus1.issuels_addr = '0;
      bus1.issuels_data = '0; bus1.issuels_ready = 1'b0; bus1.lscdb_grant = 1'b0;
      bus3.issuels_opcode = 1'b0; bus3.issuels_rdtag = '0; bus3.issuels_addr = '0;
      bus3.issuels_data = '0; bus3.issuels_ready = 1'b0; bus3.lscdb_grant = 1'b0;
      bus3.dmem_rdata = '0;

      // While reset is low, outputs stay 0 even if an operation is offered.
      #2;
      bus1.issuels_ready = 1'b1; bus1.issuels_addr = 32'h10; bus1.issuels_data = 32'h1;
      #2;
      chk("rst_done", bus1.issuels_done, 0);
      chk("rst_we",   bus1.dmem_we, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_req",  bus1.lscdb_req, 0);
      chk("rst_tag",  bus1.lscdb_tag, 0);
      step;
      reset = 1'b1;
      bus1.issuels_ready = 1'b0;

      // Test 1: a store then a load of the same word.
      step;
      bus1.issuels_ready = 1'b1; bus1.issuels_opcode = 1'b0;
      bus1.issuels_addr = 32'h0000_0010; bus1.issuels_data = 32'hDEAD_BEEF;
      #4;
      chk("st_done",  bus1.issuels_done, 1);
      chk("st_we",    bus1.dmem_we, 1);
      chk("st_re",    bus1.dmem_re, 0);
      chk("st_addr",  bus1.dmem_addr, 4);
      chk("st_wdata", bus1.dmem_wdata, 32'hDEAD_BEEF);
      step;
      bus1.issuels_opcode = 1'b1; bus1.issuels_rdtag = 6'd5; bus1.issuels_data = 32'h0;
      #4;
      chk("ld_done",  bus1.issuels_done, 1);
      chk("ld_re",    bus1.dmem_re, 1);
      chk("ld_we",    bus1.dmem_we, 0);
      chk("ld_addr",  bus1.dmem_addr, 4);
      chk("ld_wdata", bus1.dmem_wdata, 0);
      step;
      bus1.issuels_ready = 1'b0;
      #4;
      chk("mem_busy", busy1, 1);
      chk("mem_req",  bus1.lscdb_req, 0);
      chk("mem_done", bus1.issuels_done, 0);
      step;
      bus1.lscdb_grant = 1'b1;
      #4;
      chk("cdb_req",   bus1.lscdb_req, 1);
      chk("cdb_valid", bus1.lscdb_valid, 1);
      chk("cdb_tag",   bus1.lscdb_tag, 5);
      chk("cdb_data",  bus1.lscdb_data, 32'hDEAD_BEEF);
      step;
      bus1.lscdb_grant = 1'b0;
      #4;
      chk("idle_busy", busy1, 0);
      chk("idle_req",  bus1.lscdb_req, 0);
      chk("idle_tag",  bus1.lscdb_tag, 0);
      chk("idle_data", bus1.lscdb_data, 0);

      // Test 2: four back-to-back stores, one accepted per cycle.
      for (int i = 0; i < 4; i++) begin
         step;
         bus1.issuels_ready = 1'b1; bus1.issuels_opcode = 1'b0;
         bus1.issuels_addr = 32'h20 + 32'(4 * i); bus1.issuels_data = 32'h1111_0000 + 32'(i);
         #4;
         chk("b2b_done", bus1.issuels_done, 1);
         chk("b2b_busy", busy1, 0);
         chk("b2b_addr", bus1.dmem_addr, 32'(8 + i));
      end

      // Test 3: a load of 0x24 (tag 9) with the grant withheld for three cycles.
      // A store waits behind the load.
      step;
      bus1.issuels_opcode = 1'b1; bus1.issuels_rdtag = 6'd9; bus1.issuels_addr = 32'h24;
      #4;
      chk("t3_acc", bus1.issuels_done, 1);
      step;
      bus1.issuels_opcode = 1'b0; bus1.issuels_addr = 32'h40; bus1.issuels_data = 32'h55;
      #4;
      chk("t3_mem_done", bus1.issuels_done, 0);
      chk("t3_mem_we",   bus1.dmem_we, 0);
      for (int i = 0; i < 3; i++) begin
         step;
         #4;
         chk("t3_hold_req",   bus1.lscdb_req, 1);
         chk("t3_hold_valid", bus1.lscdb_valid, 0);
         chk("t3_hold_done",  bus1.issuels_done, 0);
         chk("t3_hold_tag",   bus1.lscdb_tag, 9);
      end
      step;
      bus1.lscdb_grant = 1'b1;
      #4;
      chk("t3_valid", bus1.lscdb_valid, 1);
      chk("t3_done",  bus1.issuels_done, 0);
      chk("t3_data",  bus1.lscdb_data, 32'h1111_0001);
      step;
      bus1.lscdb_grant = 1'b0;
      #4;
      chk("t3_next_done", bus1.issuels_done, 1);
      chk("t3_next_we",   bus1.dmem_we, 1);
      chk("t3_next_addr", bus1.dmem_addr, 32'h10);
      chk("t3_next_req",  bus1.lscdb_req, 0);
      step;
      bus1.issuels_ready = 1'b0;

      // Test 4: MEM_LAT=3. Read data is sampled at the end of cycle 3,
      // and the first request appears in cycle 4.
      bus3.issuels_ready = 1'b1; bus3.issuels_opcode = 1'b1; bus3.issuels_rdtag = 6'd3;
      bus3.issuels_addr = 32'h8; bus3.dmem_rdata = 32'hA000_0000;
      #4;
      chk("l3_done", bus3.issuels_done, 1);
      chk("l3_re",   bus3.dmem_re, 1);
      for (int c = 1; c <= 3; c++) begin
         step;
         bus3.issuels_ready = 1'b0;
         bus3.dmem_rdata = 32'hA000_0000 + 32'(c);
         #4;
         chk("l3_wait_req",  bus3.lscdb_req, 0);
         chk("l3_wait_busy", busy3, 1);
      end
      step;
      bus3.dmem_rdata = 32'hA000_0004; bus3.lscdb_grant = 1'b1;
      #4;
      chk("l3_req",   bus3.lscdb_req, 1);
      chk("l3_valid", bus3.lscdb_valid, 1);
      chk("l3_tag",   bus3.lscdb_tag, 3);
      chk("l3_data",  bus3.lscdb_data, 32'hA000_0003);
      step;
      bus3.lscdb_grant = 1'b0;
      #4;
      chk("l3_idle", busy3, 0);

      // Test 5: reset asserted while a load sits in MEM.
      step;
      bus1.issuels_ready = 1'b1; bus1.issuels_opcode = 1'b1; bus1.issuels_rdtag = 6'd7;
      bus1.issuels_addr = 32'h10;
      step;
      bus1.issuels_ready = 1'b0;
      #4;
      chk("r_mem_busy", busy1, 1);
      #1;
      reset = 1'b0;
      bus1.issuels_ready = 1'b1; bus1.issuels_opcode = 1'b0; bus1.lscdb_grant = 1'b1;
      #1;
      chk("r_busy",  busy1, 0);
      chk("r_done",  bus1.issuels_done, 0);
      chk("r_we",    bus1.dmem_we, 0);
      chk("r_re",    bus1.dmem_re, 0);
      chk("r_addr",  bus1.dmem_addr, 0);
      chk("r_req",   bus1.lscdb_req, 0);
      chk("r_valid", bus1.lscdb_valid, 0);
      chk("r_tag",   bus1.lscdb_tag, 0);
      chk("r_data",  bus1.lscdb_data, 0);
      step;
      step;
      reset = 1'b1;
      bus1.issuels_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step;
         #4;
         chk("r_post_req",   bus1.lscdb_req, 0);
         chk("r_post_valid", bus1.lscdb_valid, 0);
         chk("r_post_busy",  busy1, 0);
      end
      bus1.lscdb_grant = 1'b0;

      // Test 6: the byte offset is ignored and upper address bits wrap.
      step;
      bus1.issuels_ready = 1'b1; bus1.issuels_opcode = 1'b0;
      bus1.issuels_addr = 32'h0000_1003; bus1.issuels_data = 32'h1234_5678;
      #4;
      chk("wrap_addr", bus1.dmem_addr, 0);
      chk("wrap_we",   bus1.dmem_we, 1);
      step;
      bus1.issuels_ready = 1'b0;
      step;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
